// File: rtl/key_window_sequencer_if.sv
// key_window_sequencer_if
//   Key-load channel of the key window sequencer (valid/ready).
//   Optional macro KEY_PARITY_EN adds load_par (even parity over
//   {load_data, load_par}).
//   Signals:
//     load_valid  master->slave  key-load request
//     load_ready  slave->master  sequencer accepts a load this cycle
//     load_slot   master->slave  target slot 0..2 (3 = illegal / abort code)
//     load_data   master->slave  key value, KEY_W bits
//     load_par    master->slave  parity bit (KEY_PARITY_EN only)
//   Modports: master (loader side), slave (sequencer side).
interface key_window_sequencer_if #(
  parameter int unsigned KEY_W = 10
);
  logic             load_valid;
  logic             load_ready;
  logic [1:0]       load_slot;
  logic [KEY_W-1:0] load_data;
`ifdef KEY_PARITY_EN
  logic             load_par;

  modport master (
    output load_valid, load_slot, load_data, load_par,
    input  load_ready
  );
  modport slave (
    input  load_valid, load_slot, load_data, load_par,
    output load_ready
  );
`else
  modport master (
    output load_valid, load_slot, load_data,
    input  load_ready
  );
  modport slave (
    input  load_valid, load_slot, load_data,
    output load_ready
  );
`endif
endinterface

// File: rtl/key_window_sequencer.sv
// key_window_sequencer
//   Upstream key-delivery stage for a time-windowed locked FSM. Holds three
//   key slots loaded over a valid/ready channel and, once started, presents
//   the slot matching the current counter window on key_out. The internal
//   counter runs 0..PERIOD_END in lock-step with the consumer's counter; the
//   same start pulse resets both.
//   Windows: 0 -> cnt 0..WIN0_END, 1 -> WIN0_END+1..WIN1_END,
//            2 -> WIN1_END+1..PERIOD_END.
//   Optional macro KEY_PARITY_EN: loads must carry even parity over
//   {load_data, load_par}; a failing load is rejected and flags load_err.
//   Ports:
//     clk        in   clock, all state on posedge
//     rst        in   asynchronous reset, active-low
//     load       if   key-load channel (slave modport)
//     start      in   one-cycle pulse: enter RUN / resynchronise counter
//     key_out    out  KEY_W  key presented to the consumer (registered)
//     key_valid  out  key_out is a sequenced key (RUN)
//     window     out  2  current window index 0/1/2
//     load_err   out  sticky error: illegal slot, parity failure, load in
//                     RUN, or start with slots missing
module key_window_sequencer #(
  parameter int unsigned KEY_W      = 10,
  parameter int unsigned WIN0_END   = 6,
  parameter int unsigned WIN1_END   = 13,
  parameter int unsigned PERIOD_END = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  key_window_sequencer_if.slave  load,
  input  logic                   start,
  output logic [KEY_W-1:0]       key_out,
  output logic                   key_valid,
  output logic [1:0]             window,
  output logic                   load_err
);

  localparam int unsigned CNT_W = $clog2(PERIOD_END + 1);
  localparam logic [CNT_W-1:0] W0_END = CNT_W'(WIN0_END);
  localparam logic [CNT_W-1:0] W1_END = CNT_W'(WIN1_END);
  localparam logic [CNT_W-1:0] P_END  = CNT_W'(PERIOD_END);
  localparam logic [1:0]       ABORT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              slot_loaded;
  logic [2:0][KEY_W-1:0]   slots;

  logic                    par_ok;
  logic                    wr_en;
  logic [2:0]              loaded_nx;
  logic [2:0][KEY_W-1:0]   slots_nx;
  logic [CNT_W-1:0]        cnt_inc;
  logic [1:0]              win_inc;

  function automatic logic [1:0] win_of(input logic [CNT_W-1:0] c);
    if (c <= W0_END)      return 2'd0;
    else if (c <= W1_END) return 2'd1;
    else                  return 2'd2;
  endfunction

  function automatic logic [KEY_W-1:0] slot_for(input logic [2:0][KEY_W-1:0] s,
                                                input logic [1:0] w);
    case (w)
      2'd0:    return s[0];
      2'd1:    return s[1];
      default: return s[2];
    endcase
  endfunction

  // Slot write path is resolved combinationally so a start on the same
  // cycle as the final load sees the freshly written slot.
  always_comb begin
    par_ok = 1'b1;
`ifdef KEY_PARITY_EN
    par_ok = ~^{load.load_data, load.load_par};
`endif
    wr_en     = (state == IDLE) && load.load_valid &&
                (load.load_slot != ABORT) && par_ok;
    slots_nx  = slots;
    loaded_nx = slot_loaded;
    for (int unsigned i = 0; i < 3; i++) begin
      if (wr_en && (load.load_slot == 2'(i))) begin
        slots_nx[i]  = load.load_data;
        loaded_nx[i] = 1'b1;
      end
    end
    cnt_inc = (cnt == P_END) ? '0 : cnt + CNT_W'(1);
    win_inc = win_of(cnt_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      slot_loaded <= '0;
      slots       <= '0;
      key_out     <= '0;
      key_valid   <= 1'b0;
      window      <= 2'd0;
      load.load_ready <= 1'b1;
      load_err    <= 1'b0;
    end else begin
      slots       <= slots_nx;
      slot_loaded <= loaded_nx;
      case (state)
        IDLE: begin
          // Rejected load: illegal slot or (with parity) a parity failure.
          if (load.load_valid && !wr_en) load_err <= 1'b1;
          if (start) begin
            if (&loaded_nx) begin
              state           <= RUN;
              cnt             <= '0;
              window          <= 2'd0;
              key_out         <= slots_nx[0];
              key_valid       <= 1'b1;
              load.load_ready <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
          end
        end

        RUN: begin
          if (start) begin
            // Resynchronise; start takes priority over the abort code.
            cnt     <= '0;
            window  <= 2'd0;
            key_out <= slots[0];
            if (load.load_valid) load_err <= 1'b1;
          end else if (load.load_valid && (load.load_slot == ABORT)) begin
            state     <= HOLD;
            key_valid <= 1'b0;
            key_out   <= '0;
          end else begin
            // key_out follows the next count so it always matches the cnt
            // value it is held against.
            cnt     <= cnt_inc;
            window  <= win_inc;
            key_out <= slot_for(slots, win_inc);
            if (load.load_valid) load_err <= 1'b1;
          end
        end

        HOLD: begin
          state           <= IDLE;
          load.load_ready <= 1'b1;
        end

        default: begin
          state           <= IDLE;
          key_valid       <= 1'b0;
          key_out         <= '0;
          load.load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_window_sequencer.sv
// tb_key_window_sequencer
//   Directed and randomized bench for key_window_sequencer. Expected values
//   come from a cycle-level reference model of the loading / sequencing
//   rules; keys in RUN are derived from the elapsed cycles since start.
//   Parity tests are included when KEY_PARITY_EN is defined.
module tb_key_window_sequencer;

  localparam int unsigned KEY_W = 10;
  localparam int MI = 0, MR = 1, MH = 2;   // model modes: idle, run, hold

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [1:0]       window;
  logic             load_err;

  key_window_sequencer_if #(.KEY_W(KEY_W)) bus ();

  key_window_sequencer #(
    .KEY_W(KEY_W), .WIN0_END(6), .WIN1_END(13), .PERIOD_END(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.slave),
    .start     (start),
    .key_out   (key_out),
    .key_valid (key_valid),
    .window    (window),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_mode;
  int m_t;
  int m_slot [3];
  bit m_loaded [3];
  bit m_err;
  bit par_bad = 1'b0;

  function automatic int win(input int c);
    if (c <= 6)       return 0;
    else if (c <= 13) return 1;
    else              return 2;
  endfunction

  function automatic int exp_key();
    if (m_mode == MR) return m_slot[win(m_t % 21)];
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("key_valid", 32'(key_valid), 32'(m_mode == MR));
    check("key_out", 32'(key_out), 32'(exp_key()));
    check("load_ready", 32'(bus.load_ready), 32'(m_mode == MI));
    check("load_err", 32'(load_err), 32'(m_err));
    if (m_mode == MR) check("window", 32'(window), 32'(win(m_t % 21)));
  endtask

  task automatic model_step(input bit lv, input int ls, input int ld, input bit st);
    case (m_mode)
      MI: begin
        if (lv) begin
          if (ls == 3 || par_bad) m_err = 1'b1;
          else begin
            m_slot[ls]   = ld;
            m_loaded[ls] = 1'b1;
          end
        end
        if (st) begin
          if (m_loaded[0] && m_loaded[1] && m_loaded[2]) begin
            m_mode = MR;
            m_t    = 0;
          end else m_err = 1'b1;
        end
      end
      MR: begin
        if (st) begin
          m_t = 0;
          if (lv) m_err = 1'b1;
        end else if (lv && ls == 3) m_mode = MH;
        else begin
          m_t++;
          if (lv) m_err = 1'b1;
        end
      end
      default: m_mode = MI;
    endcase
  endtask

  // Drive one cycle of inputs, let one clock edge pass, check all outputs.
  task automatic cycle(input bit lv, input int ls, input int ld, input bit st);
    bus.load_valid = lv;
    bus.load_slot  = 2'(ls);
    bus.load_data  = KEY_W'(ld);
    start          = st;
`ifdef KEY_PARITY_EN
    bus.load_par   = (^bus.load_data) ^ par_bad;
`endif
    @(posedge clk);
    model_step(lv, ls, ld, st);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives.
  task automatic do_reset();
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    start          = 1'b0;
    m_mode = MI;
    m_t    = 0;
    m_err  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_slot[i]   = 0;
      m_loaded[i] = 1'b0;
    end
    #2;
    check_all();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_slot  = 2'd0;
    bus.load_data  = '0;
`ifdef KEY_PARITY_EN
    bus.load_par   = 1'b0;
`endif
    #6;
    do_reset();

    // Start with only slots 0 and 1 loaded: stays idle, error flagged.
    cycle(1'b1, 0, 'h0D2, 1'b0);
    cycle(1'b1, 1, 'h039, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    check("partial_start_err", 32'(load_err), 32'd1);
    check("partial_start_valid", 32'(key_valid), 32'd0);
    idle_cycles(2);

    // Illegal slot in idle flags error and writes nothing.
    do_reset();
    cycle(1'b1, 0, 'h0D2, 1'b0);
    cycle(1'b1, 1, 'h039, 1'b0);
    cycle(1'b1, 2, 'h35B, 1'b0);
    cycle(1'b1, 3, 'h3FF, 1'b0);
    check("slot3_err", 32'(load_err), 32'd1);
    cycle(1'b0, 0, 0, 1'b1);
    check("slot3_nowrite_key", 32'(key_out), 32'h0D2);
    idle_cycles(6);
    check("win0_last_key", 32'(key_out), 32'h0D2);

    // Clean full period including the wrap.
    do_reset();
    cycle(1'b1, 0, 'h0D2, 1'b0);
    cycle(1'b1, 1, 'h039, 1'b0);
    cycle(1'b1, 2, 'h35B, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    check("first_key_valid", 32'(key_valid), 32'd1);
    check("first_key", 32'(key_out), 32'h0D2);
    idle_cycles(7);
    check("win1_first_key", 32'(key_out), 32'h039);
    idle_cycles(7);
    check("win2_first_key", 32'(key_out), 32'h35B);
    idle_cycles(6);
    check("win2_last_key", 32'(key_out), 32'h35B);
    idle_cycles(1);
    check("wrap_key", 32'(key_out), 32'h0D2);
    check("wrap_window", 32'(window), 32'd0);

    // Resync at cnt=10.
    idle_cycles(10);
    check("pre_resync_window", 32'(window), 32'd1);
    cycle(1'b0, 0, 0, 1'b1);
    check("resync_window", 32'(window), 32'd0);
    check("resync_key", 32'(key_out), 32'h0D2);
    idle_cycles(3);

    // Abort code in RUN: HOLD then IDLE, no error.
    cycle(1'b1, 3, 0, 1'b0);
    check("abort_key", 32'(key_out), 32'd0);
    check("abort_valid", 32'(key_valid), 32'd0);
    check("abort_err", 32'(load_err), 32'd0);
    cycle(1'b0, 0, 0, 1'b0);
    check("hold_to_idle_ready", 32'(bus.load_ready), 32'd1);

    // Restart without reload, then async reset inside window 2.
    cycle(1'b0, 0, 0, 1'b1);
    check("restart_valid", 32'(key_valid), 32'd1);
    idle_cycles(16);
    check("pre_reset_window", 32'(window), 32'd2);
    do_reset();
    check("async_reset_key", 32'(key_out), 32'd0);
    cycle(1'b0, 0, 0, 1'b1);
    check("start_after_reset_err", 32'(load_err), 32'd1);

`ifdef KEY_PARITY_EN
    do_reset();
    par_bad = 1'b1;
    cycle(1'b1, 0, 'h0D2, 1'b0);
    check("par_bad_err", 32'(load_err), 32'd1);
    check("par_bad_ready", 32'(bus.load_ready), 32'd1);
    par_bad = 1'b0;
    cycle(1'b1, 0, 'h0D2, 1'b0);
    cycle(1'b1, 1, 'h039, 1'b0);
    cycle(1'b1, 2, 'h35B, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    check("par_good_key", 32'(key_out), 32'h0D2);
`endif

    // Randomized traffic against the model.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        bit lv, st;
        int ls;
        lv = ($urandom_range(0, 3) == 0);
        ls = (m_mode == MR) ? (($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)))
                            : int'($urandom_range(0, 3));
        st = ($urandom_range(0, 11) == 0);
        if (m_mode == MR && lv && $urandom_range(0, 1) == 0) lv = (ls == 3);
        cycle(lv, ls, int'($urandom_range(0, 1023)), st);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_window_sequencer.md
Name: key_window_sequencer

Overview:
- Upstream key-delivery stage for the time-windowed locked FSMs. It feeds the 10-bit key bus (keyinput0..9) of the e10-class locked block.
- Holds three key slots, loaded over a valid/ready port, and drives the slot that matches the current counter window.
- Keeps its own window counter in lock-step with the consumer's counter: 0..20 with boundaries at 6 and 13. This presents the correct key in each window without external software timing.

Parameters:
- KEY_W, 10: key width in bits.
- WIN0_END, 6: last count of window 0 (slot 0).
- WIN1_END, 13: last count of window 1 (slot 1).
- PERIOD_END, 20: last count of the period. Counter wraps to 0 after this value. Window 2 (slot 2) covers WIN1_END+1..PERIOD_END.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- load_valid  in  1  key-load request.
- load_ready  out  1  sequencer accepts a load this cycle.
- load_slot  in  2  target slot 0..2; value 3 is illegal.
- load_data  in  KEY_W  key value.
- start  in  1  one-cycle pulse that begins sequencing. The same pulse resets the consumer's counter.
- key_out  out  KEY_W  key presented to the consumer; bit i drives keyinput_i.
- key_valid  out  1  key_out is a sequenced key (RUN state).
- window  out  2  current window index 0/1/2.
- load_err  out  1  sticky; set by an illegal slot or by a load attempted while in RUN.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, slot_loaded=3'b000, slots=0, key_out=0, key_valid=0, window=0, load_ready=1, load_err=0.
- States: IDLE, RUN, HOLD.
  - IDLE: load_ready=1. When load_valid && load_slot<3, write the slot and set slot_loaded[slot]. When load_valid && load_slot==3, set load_err; no write.
  - IDLE -> RUN on start=1 when slot_loaded==3'b111 (slots written that same cycle count). If start=1 but not all slots are loaded, stay in IDLE, set load_err, key_valid stays 0.
  - RUN: load_ready=0. Any load_valid sets load_err and is dropped.
    - cnt advances by 1 each cycle and wraps PERIOD_END -> 0.
    - window = 0 if cnt<=WIN0_END, 1 if cnt<=WIN1_END, else 2.
    - key_out = slot[window], registered. The same edge that moves cnt from WIN0_END to WIN0_END+1 also switches key_out, so key_out always corresponds to the cnt value it is held against.
  - RUN entry: the edge that samples start sets cnt=0, window=0, key_out=slot0, key_valid=1.
  - start=1 while in RUN: resynchronise. cnt=0 and key_out=slot0 on that edge; state stays RUN.
  - RUN -> HOLD when start=0 && load_valid && load_slot==3 (abort code). key_valid=0, key_out=0, cnt frozen. load_err is not set by the abort code.
  - HOLD -> IDLE on the next cycle. slot_loaded is kept, so a later start re-enters RUN without reloading.
- Simultaneous events:
  - start and a legal load in IDLE on the same cycle: the load is applied first, then the start check is evaluated.
  - start and the abort code on the same cycle in RUN: start wins.
- Latency: start to first valid key is 1 cycle. Load to slot write is 1 cycle.
- Reset mid-RUN: all outputs return to their reset values immediately (async). Slot contents are lost.

Optional Feature:
- Macro: KEY_PARITY_EN.
- Defined:
  - Adds port load_par (in, 1). Even parity over {load_data, load_par} is required.
  - On a parity failure: the slot is not written, slot_loaded is not set, load_err is set, and load_ready stays 1.
- Undefined:
  - No load_par port and no parity check.

Test Plan:
- Load slots 0..2 with 0x0D2, 0x039, 0x35B, then pulse start -> key_valid=1 next cycle; key_out=0x0D2 for cnt 0..6, 0x039 for 7..13, 0x35B for 14..20, then 0x0D2 again at the wrap (22nd cycle).
- Pulse start with only slots 0 and 1 loaded -> stays IDLE, key_valid=0, load_err=1.
- In RUN at cnt=10, pulse start -> next cycle cnt=0, window=0, key_out=0x0D2.
- Load with load_slot=3 in IDLE -> load_err=1, slots unchanged. In RUN, load_slot=3 -> HOLD then IDLE, key_out=0, key_valid=0, load_err unchanged.
- Drive rst=0 asynchronously mid-window 2 -> key_out=0 and key_valid=0 before the next clk edge; start after reset without reload -> load_err=1.
- With KEY_PARITY_EN defined: load 0x0D2 with load_par=1 (wrong) -> load_err=1, slot 0 not loaded. Load 0x0D2 with load_par=0 -> slot 0 loaded.
